// File: rtl/lcd_cmd_seq.sv
// -----------------------------------------------------------------------------
// lcd_cmd_seq
//
// Command sequencer that sits directly in front of a 4-bit LCD nibble
// controller. After reset it waits for the panel's power-on delay. It then
// plays the fixed HD44780 4-bit initialisation list and raises init_done_o.
// From then on it accepts user bytes (instruction or character) on a
// valid/ready handshake. Each byte is sent as two nibble frames, high nibble
// first. Every entry is followed by a settle delay that depends on the
// command.
//
// Ports
//   clk_i         system clock
//   rst_i         asynchronous, active-high reset
//   cmd_valid_i   user request valid
//   cmd_ready_o   sequencer accepts a byte this cycle (only in READY)
//   cmd_rs_i      0 = instruction, 1 = character data
//   cmd_data_i    byte to send
//   init_done_o   init list complete, sticky until reset
//   lcd_start_o   one-cycle start pulse to the nibble controller
//   lcd_rs_o      rs to the nibble controller
//   lcd_rw_o      rw to the nibble controller, always 0 (write-only)
//   lcd_datain_o  nibble in [7:4], [3:0] always 0
//
// Timing model
//   All outputs are registered. A pulse edge is the clock edge that sets
//   lcd_start_o. At that edge the delay counter is loaded with (delay - 1).
//   The counter decrements once per cycle. The next pulse (or cmd_ready_o)
//   fires on the edge where the counter reads 0. Therefore the next event
//   lands exactly "delay" cycles after the pulse.
//   The power-on wait is the exception. Reset loads the full PWR_DLY, so the
//   first pulse lands PWR_DLY cycles after the first edge with rst_i low.
// -----------------------------------------------------------------------------
module lcd_cmd_seq #(
   parameter int PWR_DLY  = 750000,
   parameter int INIT_DLY = 205000,
   parameter int CMD_DLY  = 2000,
   parameter int CLR_DLY  = 82000,
   parameter int NIB_GAP  = 8,
   parameter int CNT_W    = 20
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_rs_i,
   input  logic [7:0] cmd_data_i,
   output logic       init_done_o,
   output logic       lcd_start_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic [7:0] lcd_datain_o
);

   typedef enum logic [2:0] {
      S_PWR_WAIT,
      S_ISSUE_HI,
      S_GAP,
      S_ISSUE_LO,
      S_WAIT,
      S_READY
   } state_t;

   // Counter reload values. Delays are stored already reduced by one, because
   // the load happens on the pulse edge itself.
   localparam logic [CNT_W-1:0] PWR_CNT  = CNT_W'(PWR_DLY);
   localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_DLY - 1);
   localparam logic [CNT_W-1:0] CMD_CNT  = CNT_W'(CMD_DLY - 1);
   localparam logic [CNT_W-1:0] CLR_CNT  = CNT_W'(CLR_DLY - 1);
   localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(NIB_GAP - 1);

   localparam logic [3:0] INIT_ENTRIES = 4'd8;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       idx_q;        // next init entry to issue
   logic [3:0]       lo_nib_q;     // low nibble waiting for the second frame
   logic [CNT_W-1:0] dly_q;        // settle reload for the current entry
   logic             two_nib_q;
   logic             init_done_q;
   logic             ready_q;
   logic             start_q;
   logic             rs_q;
   logic [3:0]       nib_q;        // nibble currently presented on datain

   // Description of the entry that would be issued if a pulse fired now.
   logic [7:0]       entry_byte_d;
   logic             entry_rs_d;
   logic             entry_two_d;
   logic [CNT_W-1:0] entry_dly_d;
   logic             fire_d;
   logic             user_clr;
   logic [CNT_W-1:0] cnt_dec;

   // Counter never wraps: it holds at zero.
   assign cnt_dec = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;

   // Clear display (0x01), return home (0x02/0x03) need the long settle.
   assign user_clr = ~cmd_rs_i &
                     ((cmd_data_i == 8'h01) || (cmd_data_i == 8'h02) ||
                      (cmd_data_i == 8'h03));

   always_comb begin
      entry_byte_d = 8'h00;
      entry_rs_d   = 1'b0;
      entry_two_d  = 1'b0;
      entry_dly_d  = CMD_CNT;
      if (init_done_q) begin
         entry_byte_d = cmd_data_i;
         entry_rs_d   = cmd_rs_i;
         entry_two_d  = 1'b1;
         entry_dly_d  = user_clr ? CLR_CNT : CMD_CNT;
      end else begin
         // Fixed init list. Single-nibble entries keep their nibble in [7:4].
         case (idx_q[2:0])
            3'd0:    begin entry_byte_d = 8'h30; entry_two_d = 1'b0; entry_dly_d = INIT_CNT; end
            3'd1:    begin entry_byte_d = 8'h30; entry_two_d = 1'b0; entry_dly_d = INIT_CNT; end
            3'd2:    begin entry_byte_d = 8'h30; entry_two_d = 1'b0; entry_dly_d = CMD_CNT;  end
            3'd3:    begin entry_byte_d = 8'h20; entry_two_d = 1'b0; entry_dly_d = CMD_CNT;  end
            3'd4:    begin entry_byte_d = 8'h28; entry_two_d = 1'b1; entry_dly_d = CMD_CNT;  end
            3'd5:    begin entry_byte_d = 8'h0C; entry_two_d = 1'b1; entry_dly_d = CMD_CNT;  end
            3'd6:    begin entry_byte_d = 8'h01; entry_two_d = 1'b1; entry_dly_d = CLR_CNT;  end
            default: begin entry_byte_d = 8'h06; entry_two_d = 1'b1; entry_dly_d = CMD_CNT;  end
         endcase
      end

      // A new entry starts in one of three cases:
      //   - the power-on wait expires;
      //   - an init settle expires with list entries left;
      //   - a user handshake completes.
      fire_d = 1'b0;
      case (state_q)
         S_PWR_WAIT: fire_d = (cnt_q == '0);
         S_WAIT:     fire_d = (cnt_q == '0) && !init_done_q && (idx_q != INIT_ENTRIES);
         S_READY:    fire_d = cmd_valid_i & ready_q;
         default:    fire_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_PWR_WAIT;
         cnt_q       <= PWR_CNT;
         idx_q       <= 4'd0;
         lo_nib_q    <= 4'h0;
         dly_q       <= '0;
         two_nib_q   <= 1'b0;
         init_done_q <= 1'b0;
         ready_q     <= 1'b0;
         start_q     <= 1'b0;
         rs_q        <= 1'b0;
         nib_q       <= 4'h0;
      end else if (fire_d) begin
         // High-nibble (or only) pulse of a new entry.
         state_q   <= S_ISSUE_HI;
         start_q   <= 1'b1;
         ready_q   <= 1'b0;
         rs_q      <= entry_rs_d;
         nib_q     <= entry_byte_d[7:4];
         lo_nib_q  <= entry_byte_d[3:0];
         two_nib_q <= entry_two_d;
         dly_q     <= entry_dly_d;
         cnt_q     <= entry_two_d ? GAP_CNT : entry_dly_d;
         if (!init_done_q) begin
            idx_q <= idx_q + 4'd1;
         end
      end else begin
         start_q <= 1'b0;
         case (state_q)
            S_PWR_WAIT: begin
               cnt_q <= cnt_dec;
            end
            S_ISSUE_HI: begin
               cnt_q   <= cnt_dec;
               state_q <= two_nib_q ? S_GAP : S_WAIT;
            end
            S_GAP: begin
               if (cnt_q == '0) begin
                  start_q <= 1'b1;
                  nib_q   <= lo_nib_q;
                  cnt_q   <= dly_q;
                  state_q <= S_ISSUE_LO;
               end else begin
                  cnt_q <= cnt_dec;
               end
            end
            S_ISSUE_LO: begin
               cnt_q   <= cnt_dec;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // A remaining init entry would have taken the fire_d branch.
               // Reaching zero here means the sequencer is idle.
               if (cnt_q == '0) begin
                  init_done_q <= 1'b1;
                  ready_q     <= 1'b1;
                  state_q     <= S_READY;
               end else begin
                  cnt_q <= cnt_dec;
               end
            end
            S_READY: begin
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_PWR_WAIT;
               cnt_q   <= PWR_CNT;
            end
         endcase
      end
   end

   assign cmd_ready_o  = ready_q;
   assign init_done_o  = init_done_q;
   assign lcd_start_o  = start_q;
   assign lcd_rs_o     = rs_q;
   assign lcd_rw_o     = 1'b0;
   assign lcd_datain_o = {nib_q, 4'h0};

endmodule

// File: tb/tb_lcd_cmd_seq.sv
module tb_lcd_cmd_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_rs = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready;
   logic       init_done;
   logic       lcd_start;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_datain;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Expected init pulses: cycle index and datain value.
   int         pc [12] = '{20, 30, 40, 46, 52, 56, 62, 66, 72, 76, 88, 92};
   logic [7:0] pd [12] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80,
                           8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h60};

   lcd_cmd_seq #(
      .PWR_DLY (20),
      .INIT_DLY(10),
      .CMD_DLY (6),
      .CLR_DLY (12),
      .NIB_GAP (4),
      .CNT_W   (20)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_rs_i    (cmd_rs),
      .cmd_data_i  (cmd_data),
      .init_done_o (init_done),
      .lcd_start_o (lcd_start),
      .lcd_rs_o    (lcd_rs),
      .lcd_rw_o    (lcd_rw),
      .lcd_datain_o(lcd_datain)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Advance one clock; sampling happens on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Invariant monitor
   int   mcyc = 0;
   int   last_start = -100;
   logic prev_start = 1'b0;
   always @(negedge clk) begin
      mcyc++;
      if (rst) begin
         prev_start = 1'b0;
      end else begin
         check("rw_zero", {31'd0, lcd_rw}, 32'd0);
         check("datain_low_zero", {28'd0, lcd_datain[3:0]}, 32'd0);
         if (lcd_start) begin
            check("start_single_cycle", {31'd0, prev_start}, 32'd0);
            check("start_spacing", {31'd0, (mcyc - last_start) >= 4}, 32'd1);
            last_start = mcyc;
         end
         prev_start = lcd_start;
      end
   end

   // Called right after rst is released at a falling edge with cyc = -1.
   task automatic check_init();
      int  p;
      logic exp_s;
      p = 0;
      for (int k = 0; k <= 98; k++) begin
         step();
         exp_s = (p < 12) && (cyc == pc[p]);
         check("init_start", {31'd0, lcd_start}, {31'd0, exp_s});
         if (exp_s) begin
            check("init_datain", {24'd0, lcd_datain}, {24'd0, pd[p]});
            check("init_rs", {31'd0, lcd_rs}, 32'd0);
            p++;
         end
         check("init_ready", {31'd0, cmd_ready}, {31'd0, cyc >= 98});
         check("init_done", {31'd0, init_done}, {31'd0, cyc >= 98});
      end
      check("init_pulse_count", p, 12);
      $display("init sequence: %0d pulses seen, init_done=%0b at cycle %0d", p, init_done, cyc);
   endtask

   // One user byte. If keep is set, cmd_valid stays high afterwards.
   task automatic xfer(input logic rs, input logic [7:0] data, input int dly, input bit keep);
      int w;
      int t;
      w = 0;
      while (!cmd_ready && w < 300) begin
         step();
         w++;
      end
      check("ready_wait", {31'd0, cmd_ready}, 32'd1);
      if (!cmd_ready) return;
      t = cyc;
      cmd_valid = 1'b1;
      cmd_rs    = rs;
      cmd_data  = data;
      step();
      if (!keep) cmd_valid = 1'b0;
      // Changing inputs while cmd_ready is low must have no effect.
      cmd_data = ~data;
      cmd_rs   = ~rs;
      check("hi_start", {31'd0, lcd_start}, 32'd1);
      check("hi_datain", {24'd0, lcd_datain}, {24'd0, data[7:4], 4'h0});
      check("hi_rs", {31'd0, lcd_rs}, {31'd0, rs});
      check("hi_ready_low", {31'd0, cmd_ready}, 32'd0);
      for (int i = 2; i <= 4; i++) begin
         step();
         check("gap_start", {31'd0, lcd_start}, 32'd0);
         check("gap_datain_hold", {24'd0, lcd_datain}, {24'd0, data[7:4], 4'h0});
         check("gap_rs_hold", {31'd0, lcd_rs}, {31'd0, rs});
         check("gap_ready_low", {31'd0, cmd_ready}, 32'd0);
      end
      step();
      check("lo_start", {31'd0, lcd_start}, 32'd1);
      check("lo_datain", {24'd0, lcd_datain}, {24'd0, data[3:0], 4'h0});
      check("lo_rs", {31'd0, lcd_rs}, {31'd0, rs});
      for (int i = 1; i < dly; i++) begin
         step();
         check("settle_start", {31'd0, lcd_start}, 32'd0);
         check("settle_ready_low", {31'd0, cmd_ready}, 32'd0);
         check("settle_datain_hold", {24'd0, lcd_datain}, {24'd0, data[3:0], 4'h0});
      end
      step();
      check("ready_return", {31'd0, cmd_ready}, 32'd1);
      check("ready_start_low", {31'd0, lcd_start}, 32'd0);
      $display("xfer rs=%0b data=0x%02h accepted@%0d settle=%0d ready@%0d", rs, data, t, dly, cyc);
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_start", {31'd0, lcd_start}, 32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_rs", {31'd0, lcd_rs}, 32'd0);
      check("rst_datain", {24'd0, lcd_datain}, 32'd0);

      // Hold a request throughout init; it must not transfer before init_done.
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h41;
      rst = 1'b0;
      cyc = -1;
      check_init();

      // The pending character transfers the first cycle cmd_ready is seen.
      xfer(1'b1, 8'h41, 6, 1'b0);
      xfer(1'b0, 8'h01, 12, 1'b0);
      xfer(1'b1, 8'h01, 6, 1'b0);
      xfer(1'b0, 8'h02, 12, 1'b0);
      xfer(1'b0, 8'h03, 12, 1'b0);
      xfer(1'b0, 8'h04, 6, 1'b0);
      xfer(1'b0, 8'h00, 6, 1'b0);

      // Back-to-back with cmd_valid held high.
      xfer(1'b1, 8'hA5, 6, 1'b1);
      xfer(1'b0, 8'h80, 6, 1'b1);
      xfer(1'b1, 8'h3C, 6, 1'b1);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle_ready", {31'd0, cmd_ready}, 32'd1);
         check("idle_start", {31'd0, lcd_start}, 32'd0);
      end

      // Reset two cycles after a hi pulse.
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h5A;
      step();
      cmd_valid = 1'b0;
      check("midop_hi_start", {31'd0, lcd_start}, 32'd1);
      check("midop_hi_datain", {24'd0, lcd_datain}, 32'h50);
      step();
      step();
      rst = 1'b1;
      #1;
      check("midrst_start", {31'd0, lcd_start}, 32'd0);
      check("midrst_datain", {24'd0, lcd_datain}, 32'd0);
      check("midrst_rs", {31'd0, lcd_rs}, 32'd0);
      check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
      check("midrst_init_done", {31'd0, init_done}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("midrst_no_lo_pulse", {31'd0, lcd_start}, 32'd0);
      end
      $display("reset mid-frame: outputs cleared, no low-nibble pulse");
      rst = 1'b0;
      cyc = -1;
      check_init();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
